// File: rtl/uart_tx_pkg.sv
// Shared constants and FSM encoding for the UART transmit feeder.
package uart_tx_pkg;

  localparam int UART_FRAME_CYCLES = 12;
  localparam int UART_DATA_W       = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LAUNCH = 2'b01,
    ST_WAIT   = 2'b10
  } tx_state_e;

endpackage

// File: rtl/uart_tx_sync_fifo.sv
// Small synchronous byte FIFO with registered occupancy flags and an overflow pulse.
module uart_tx_sync_fifo
  import uart_tx_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int DATA_W = UART_DATA_W
) (
  input  logic              clock_tx,
  input  logic              reset_tx,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W:0]   count_o,
  output logic              overflow_o
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              overflow_q, overflow_d;
  logic              wr_accept;
  logic              rd_accept;

  // Write side: a byte is taken when wr_en_i is high and full_o is low at the
  // clock edge; wr_en_i while full_o is high drops the byte and flags overflow.
  assign wr_accept = wr_en_i && !full_q;
  assign rd_accept = rd_en_i && !empty_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = wr_en_i && full_q;
    if (wr_accept) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (rd_accept) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == FULL_COUNT);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clock_tx or negedge reset_tx) begin
    if (!reset_tx) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: stale entries are unreachable once the pointers clear.
  always_ff @(posedge clock_tx) begin
    if (wr_accept) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o  = mem_q[rd_ptr_q];
  assign full_o     = full_q;
  assign empty_o    = empty_q;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/uart_tx_feeder.sv
// Pops queued bytes one at a time, launches the UART transmitter and holds the
// byte until the fixed-length frame has completed.
module uart_tx_feeder
  import uart_tx_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int ADDR_W       = 3,
  parameter int FRAME_CYCLES = UART_FRAME_CYCLES
) (
  input  logic                   clock_tx,
  input  logic                   reset_tx,
  input  logic                   wr_en,
  input  logic [UART_DATA_W-1:0] wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [ADDR_W:0]        count,
  output logic                   overflow,
  output logic                   tx_start,
  output logic [UART_DATA_W-1:0] data_in_tx,
  output logic                   busy_tx,
  output logic [1:0]             fsm_state_o
);

  localparam int CNT_W = $clog2(FRAME_CYCLES + 1);

  tx_state_e              state_q, state_d;
  logic [CNT_W-1:0]       frame_cnt_q, frame_cnt_d;
  logic [UART_DATA_W-1:0] data_q, data_d;
  logic                   tx_start_q, tx_start_d;
  logic                   busy_q, busy_d;
  logic                   pop;
  logic [UART_DATA_W-1:0] fifo_rd_data;
  logic                   fifo_empty;

  uart_tx_sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (UART_DATA_W)
  ) u_fifo (
    .clock_tx   (clock_tx),
    .reset_tx   (reset_tx),
    .wr_en_i    (wr_en),
    .wr_data_i  (wr_data),
    .rd_en_i    (pop),
    .rd_data_o  (fifo_rd_data),
    .full_o     (full),
    .empty_o    (fifo_empty),
    .count_o    (count),
    .overflow_o (overflow)
  );

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    data_d      = data_q;
    pop         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          data_d  = fifo_rd_data;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        frame_cnt_d = CNT_W'(FRAME_CYCLES - 1);
        state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        // Leaving at count 1 leaves one idle-line cycle before the next launch.
        frame_cnt_d = frame_cnt_q - CNT_W'(1);
        if (frame_cnt_q <= CNT_W'(1)) begin
          frame_cnt_d = '0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    tx_start_d = (state_d == ST_LAUNCH);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock_tx or negedge reset_tx) begin
    if (!reset_tx) begin
      state_q     <= ST_IDLE;
      frame_cnt_q <= '0;
      data_q      <= '0;
      tx_start_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      data_q      <= data_d;
      tx_start_q  <= tx_start_d;
      busy_q      <= busy_d;
    end
  end

  assign empty       = fifo_empty;
  assign tx_start    = tx_start_q;
  assign data_in_tx  = data_q;
  assign busy_tx     = busy_q;
  assign fsm_state_o = state_q;

endmodule
